seg7_frame_driver: RTL and testbench

// Downstream partner of the 4-digit anode scan generator: consumes its digit

---
 rtl/seg7_frame_driver.sv | 143 ++++++++++++++
 tb/tb_seg7_frame_driver.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_frame_driver.sv
// Cathode driver for a 4-digit multiplexed 7-segment display, slaved to an anode scan generator.
// A double-buffered word is swapped in only at frame boundaries. Also does leading-zero blanking and per-digit blink.
`timescale 1ns/1ps
module seg7_frame_driver #(
  parameter int BLINK_W = 3,
  parameter bit LZB_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic [1:0]  q,
  input  logic [15:0] din,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blink_in,
  input  logic        load_valid,
  output logic        load_ready,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    unique case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [15:0]        act_data_q, act_data_d;
  logic [3:0]         act_dp_q, act_dp_d;
  logic [3:0]         act_bl_q, act_bl_d;
  logic [15:0]        pnd_data_q, pnd_data_d;
  logic [3:0]         pnd_dp_q, pnd_dp_d;
  logic [3:0]         pnd_bl_q, pnd_bl_d;
  logic               pnd_full_q, pnd_full_d;
  logic [BLINK_W-1:0] fcnt_q, fcnt_d;
  logic               frame_tick_q;

  logic fb;
  logic load_fire;
  logic bph;

  // Last scan step of the frame: the scan generator is about to wrap q back to 0.
  assign fb        = ce && (q == 2'd3);
  assign load_fire = load_valid && !pnd_full_q;
  assign bph       = fcnt_q[BLINK_W-1];

  always_comb begin
    act_data_d = act_data_q;
    act_dp_d   = act_dp_q;
    act_bl_d   = act_bl_q;
    pnd_data_d = pnd_data_q;
    pnd_dp_d   = pnd_dp_q;
    pnd_bl_d   = pnd_bl_q;
    pnd_full_d = pnd_full_q;
    fcnt_d     = fcnt_q;
    if (load_fire) begin
      pnd_data_d = din;
      pnd_dp_d   = dp_in;
      pnd_bl_d   = blink_in;
      pnd_full_d = 1'b1;
    end
    // load_fire needs an empty buffer, so it never collides with a swap.
    if (fb) begin
      fcnt_d = fcnt_q + BLINK_W'(1);
      if (pnd_full_q) begin
        act_data_d = pnd_data_q;
        act_dp_d   = pnd_dp_q;
        act_bl_d   = pnd_bl_q;
        pnd_full_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_bl_q     <= '0;
      pnd_data_q   <= '0;
      pnd_dp_q     <= '0;
      pnd_bl_q     <= '0;
      pnd_full_q   <= 1'b0;
      fcnt_q       <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_bl_q     <= act_bl_d;
      pnd_data_q   <= pnd_data_d;
      pnd_dp_q     <= pnd_dp_d;
      pnd_bl_q     <= pnd_bl_d;
      pnd_full_q   <= pnd_full_d;
      fcnt_q       <= fcnt_d;
      frame_tick_q <= fb;
    end
  end

  assign load_ready = !pnd_full_q;
  assign frame_tick = frame_tick_q;

  // upper_zero[i]: nibble i and every nibble above it are zero.
  logic [3:0] nib_zero;
  logic [3:0] upper_zero;
  for (genvar gi = 0; gi < 4; gi++) begin : g_lzb
    assign nib_zero[gi] = (act_data_q[4*gi +: 4] == 4'h0);
    if (gi == 3) begin : g_top
      assign upper_zero[gi] = nib_zero[gi];
    end else begin : g_low
      assign upper_zero[gi] = nib_zero[gi] && upper_zero[gi+1];
    end
  end

  // Purely combinational from q so the cathodes track the anode with no lag.
  always_comb begin
    seg = hex7(act_data_q[{q, 2'b00} +: 4]);
    dp  = !act_dp_q[q];
    if (LZB_EN && (q != 2'd0) && upper_zero[q]) begin
      seg = 7'h7F;
    end
    if (act_bl_q[q] && bph) begin
      seg = 7'h7F;
      dp  = 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_frame_driver.sv
// Bench for seg7_frame_driver: two instances (zero blanking on/off) checked every cycle
// against a word/queue-level model, plus directed literal checks.
`timescale 1ns/1ps
module tb_seg7_frame_driver;
  localparam int BLINK_W = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic [1:0]  q = 2'd0;
  logic [15:0] din = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blink_in = 4'h0;
  logic        load_valid = 1'b0;

  logic        ready1, dp1, tick1, ready0, dp0, tick0;
  logic [6:0]  seg1, seg0;

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  seg7_frame_driver #(.BLINK_W(BLINK_W), .LZB_EN(1'b1)) u_lzb1 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .q(q), .din(din), .dp_in(dp_in),
    .blink_in(blink_in), .load_valid(load_valid), .load_ready(ready1),
    .seg(seg1), .dp(dp1), .frame_tick(tick1));

  seg7_frame_driver #(.BLINK_W(BLINK_W), .LZB_EN(1'b0)) u_lzb0 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .q(q), .din(din), .dp_in(dp_in),
    .blink_in(blink_in), .load_valid(load_valid), .load_ready(ready0),
    .seg(seg0), .dp(dp0), .frame_tick(tick0));

  // Reference model: displayed word, a queue holding at most one pending word,
  // and an unbounded frame count.
  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  dp;
    logic [3:0]  bl;
  } word_t;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  word_t m_act = '0;
  word_t m_pend[$];
  int    m_frames = 0;
  bit    m_tick = 1'b0;
  bit    m_fb, m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = '0;
      m_pend.delete();
      m_frames = 0;
      m_tick = 1'b0;
    end else begin
      m_fb  = ce && (q == 2'd3);
      m_acc = load_valid && (m_pend.size() == 0);
      m_tick = m_fb;
      if (m_fb) begin
        m_frames++;
        if (m_pend.size() != 0) m_act = m_pend.pop_front();
      end
      if (m_acc) m_pend.push_back({din, dp_in, blink_in});
    end
  end

  function automatic logic [7:0] model_out(input bit lzb, input logic [1:0] qq);
    logic [15:0] upper;
    logic [6:0]  s;
    logic        d;
    upper = m_act.d >> (4 * qq);
    s = seg_tab[upper[3:0]];
    d = !m_act.dp[qq];
    if (lzb && qq != 2'd0 && upper == 16'h0) s = 7'h7F;
    if (m_act.bl[qq] && ((m_frames / (1 << (BLINK_W - 1))) % 2 == 1)) begin
      s = 7'h7F;
      d = 1'b1;
    end
    return {s, d};
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      cmp("model_seg_dp_lzb1", {seg1, dp1}, model_out(1'b1, q));
      cmp("model_seg_dp_lzb0", {seg0, dp0}, model_out(1'b0, q));
      cmp("model_ready_lzb1", ready1, m_pend.size() == 0);
      cmp("model_ready_lzb0", ready0, m_pend.size() == 0);
      cmp("model_tick_lzb1", tick1, m_tick);
      cmp("model_tick_lzb0", tick0, m_tick);
    end
  end

  // One clock with the given ce/valid; q follows the scan generator on ce.
  task automatic cyc(input bit ce_v, input bit v_v);
    ce = ce_v;
    load_valid = v_v;
    @(posedge clk);
    #1;
    if (ce) q = q + 2'd1;
    ce = 1'b0;
    load_valid = 1'b0;
  endtask

  task automatic lit(input string name, input logic [1:0] qv, input logic [6:0] e1,
                     input logic [6:0] e0, input logic ed);
    @(posedge clk);
    #1;
    q = qv;
    #1;
    cmp({name, "_seg_lzb1"}, seg1, e1);
    cmp({name, "_seg_lzb0"}, seg0, e0);
    cmp({name, "_dp"}, dp1, ed);
  endtask

  initial begin
    check_en = 1'b1;
    // Reset state
    lit("rst_q0", 2'd0, 7'h40, 7'h40, 1'b1);
    lit("rst_q1", 2'd1, 7'h7F, 7'h40, 1'b1);
    lit("rst_q2", 2'd2, 7'h7F, 7'h40, 1'b1);
    lit("rst_q3", 2'd3, 7'h7F, 7'h40, 1'b1);
    cmp("rst_ready", ready1, 1);
    cmp("rst_tick", tick1, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Load, display changes only after the frame boundary
    q = 2'd0;
    din = 16'h12AF;
    cyc(1'b0, 1'b1);
    cmp("load_ready_low", ready1, 0);
    cmp("load_hold_seg", seg1, 7'h40);
    q = 2'd3;
    cyc(1'b1, 1'b0);
    cmp("fb_tick", tick1, 1);
    cmp("swap_ready", ready1, 1);
    lit("w12af_q0", 2'd0, 7'h0E, 7'h0E, 1'b1);
    lit("w12af_q1", 2'd1, 7'h08, 7'h08, 1'b1);
    lit("w12af_q2", 2'd2, 7'h24, 7'h24, 1'b1);
    lit("w12af_q3", 2'd3, 7'h79, 7'h79, 1'b1);

    // Leading-zero blanking
    din = 16'h0001;
    cyc(1'b0, 1'b1);
    q = 2'd3;
    cyc(1'b1, 1'b0);
    lit("w0001_q3", 2'd3, 7'h7F, 7'h40, 1'b1);
    lit("w0001_q2", 2'd2, 7'h7F, 7'h40, 1'b1);
    lit("w0001_q1", 2'd1, 7'h7F, 7'h40, 1'b1);
    lit("w0001_q0", 2'd0, 7'h79, 7'h79, 1'b1);

    // Back-to-back loads stall until after the frame boundary
    din = 16'h0033;
    cyc(1'b0, 1'b1);
    din = 16'h4444;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1);
      cmp("b2b_stall", ready1, 0);
    end
    lit("b2b_old_q0", 2'd0, 7'h79, 7'h79, 1'b1);
    q = 2'd3;
    cyc(1'b1, 1'b1);
    cmp("b2b_ready_after_fb", ready1, 1);
    cyc(1'b0, 1'b1);
    cmp("b2b_second_taken", ready1, 0);
    lit("w0033_q0", 2'd0, 7'h30, 7'h30, 1'b1);
    lit("w0033_q2", 2'd2, 7'h7F, 7'h40, 1'b1);
    q = 2'd3;
    cyc(1'b1, 1'b0);
    lit("w4444_q2", 2'd2, 7'h19, 7'h19, 1'b1);

    // Blink on digit 2 over 16 frames, from a known frame count
    rst_n = 1'b0;
    cyc(1'b0, 1'b0);
    rst_n = 1'b1;
    din = 16'h5555;
    dp_in = 4'b0010;
    blink_in = 4'b0100;
    cyc(1'b0, 1'b1);
    dp_in = 4'h0;
    blink_in = 4'h0;
    q = 2'd3;
    cyc(1'b1, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      lit("blink_d2", 2'd2, ((k % 8) >= 4) ? 7'h7F : 7'h12, ((k % 8) >= 4) ? 7'h7F : 7'h12, 1'b1);
      lit("blink_d1", 2'd1, 7'h12, 7'h12, 1'b0);
      q = 2'd3;
      cyc(1'b1, 1'b0);
    end

    // Load on the frame-boundary cycle is shown one frame later
    din = 16'h7777;
    q = 2'd3;
    cyc(1'b1, 1'b1);
    cmp("fbload_pending", ready1, 0);
    lit("fbload_old_q0", 2'd0, 7'h12, 7'h12, 1'b1);
    q = 2'd3;
    cyc(1'b1, 1'b0);
    lit("fbload_new_q0", 2'd0, 7'h78, 7'h78, 1'b1);

    // Reset mid-frame drops the pending word
    din = 16'h9999;
    cyc(1'b0, 1'b1);
    q = 2'd2;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    q = 2'd0;
    #1;
    cmp("midrst_seg", seg1, 7'h40);
    cmp("midrst_ready", ready1, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      din = 16'($urandom);
      dp_in = 4'($urandom);
      blink_in = 4'($urandom);
      if ($urandom_range(0, 49) == 0) q = 2'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        cyc(1'b0, 1'b0);
        rst_n = 1'b1;
      end else begin
        cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
      end
    end

    @(posedge clk);
    #1;
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
